wb_arbiter_n: RTL and testbench

Parametrised N-master to 1-slave Wishbone arbiter. It generalises the fixed two-port instruction/data cache interconnect to any number of L1 requesters, with a selectable fixed-priority or round-robin policy and per-master grant counters. It sits between the L1 caches and the shared L2 cache.

---
 rtl/wb_arbiter_n_pkg.sv | 33 +++
 rtl/wb_arbiter_n_if.sv | 41 ++++
 rtl/wb_arbiter_n_pick.sv | 23 ++
 rtl/wb_arbiter_n.sv | 127 ++++++++++++
 tb/tb_wb_arbiter_n.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_n_pkg.sv
// Shared types and the winner-selection helper for the N-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int MAX_M = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Unused request bits above NUM_M are zero, so wrapping modulo MAX_M gives
    // the same winner as wrapping modulo NUM_M whenever ptr < NUM_M.
    function automatic logic [2:0] rr_pick(input logic [MAX_M-1:0] req,
                                           input logic [2:0]       ptr,
                                           input logic             mode);
        logic [2:0] start;
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        start = mode ? ptr : 3'd0;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < MAX_M; k++) begin
            idx = start + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/wb_arbiter_n_if.sv
// Wishbone bundle between the L1 requesters, the arbiter and the shared L2 slave.
interface wb_arbiter_n_if #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int SEL_W  = DATA_W / 8
);
    logic [NUM_M-1:0]        m_cyc;
    logic [NUM_M-1:0]        m_stb;
    logic [NUM_M-1:0]        m_we;
    logic [NUM_M*ADDR_W-1:0] m_adr;
    logic [NUM_M*SEL_W-1:0]  m_sel;
    logic [NUM_M*DATA_W-1:0] m_dat_w;
    logic [DATA_W-1:0]       m_dat_r;
    logic [NUM_M-1:0]        m_ack;
    logic [NUM_M-1:0]        m_rty;
    logic                    s_cyc;
    logic                    s_stb;
    logic                    s_we;
    logic [ADDR_W-1:0]       s_adr;
    logic [SEL_W-1:0]        s_sel;
    logic [DATA_W-1:0]       s_dat_w;
    logic [DATA_W-1:0]       s_dat_r;
    logic                    s_ack;
    logic                    s_rty;

    // slave: the arbiter, which serves the L1 masters and drives the L2 side
    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_w,
        output m_dat_r, m_ack, m_rty,
        output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w,
        input  s_dat_r, s_ack, s_rty
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_w,
        input  m_dat_r, m_ack, m_rty,
        input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_w,
        output s_dat_r, s_ack, s_rty
    );
endinterface

// File: rtl/wb_arbiter_n_pick.sv
// Combinational winner picker: lowest index in fixed mode, first at/after ptr in round-robin.
module wb_arb_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_M = 2
) (
    input  logic [NUM_M-1:0] req,
    input  logic [2:0]       ptr,
    input  logic             mode_rr,
    output logic [2:0]       win,
    output logic             any
);
    logic [MAX_M-1:0] req_pad;

    always_comb begin
        req_pad              = '0;
        req_pad[NUM_M-1:0]   = req;
    end

    assign win = rr_pick(req_pad, ptr, mode_rr);
    assign any = |req;

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone arbiter between the L1 caches and the shared L2.
// state | meaning
// IDLE  | no slave cycle; arbitrate among pending requests
// GRANT | gnt_idx owns the slave until ack, retry or request drop
module wb_arbiter_n
    import wb_arb_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int SEL_W  = DATA_W / 8,
    parameter int CNT_W  = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   mode_rr,
    wb_arbiter_n_if.slave          bus,
    output logic [NUM_M*CNT_W-1:0] gnt_cnt,
    output logic                   busy
);
    localparam logic [2:0] LAST_IDX = 3'(NUM_M - 1);

    arb_state_t        state;
    logic [2:0]        gnt_idx;
    logic [2:0]        rr_ptr;
    logic [2:0]        win;
    logic              any_req;
    logic              granted;
    logic              gnt_req;
    logic [NUM_M-1:0]  req;
    logic [MAX_M-1:0]  req_pad;
    logic [MAX_M-1:0]  we_arr;
    logic [ADDR_W-1:0] adr_arr [MAX_M];
    logic [SEL_W-1:0]  sel_arr [MAX_M];
    logic [DATA_W-1:0] dat_arr [MAX_M];
    logic [CNT_W-1:0]  cnt     [NUM_M];

    assign req = bus.m_cyc & bus.m_stb;

    wb_arb_pick #(.NUM_M(NUM_M)) u_pick (
        .req     (req),
        .ptr     (rr_ptr),
        .mode_rr (mode_rr),
        .win     (win),
        .any     (any_req)
    );

    // Pad per-master fields to MAX_M entries so a 3-bit gnt_idx indexes them cleanly.
    always_comb begin
        req_pad = '0;
        we_arr  = '0;
        for (int i = 0; i < MAX_M; i++) begin
            adr_arr[i] = '0;
            sel_arr[i] = '0;
            dat_arr[i] = '0;
        end
        for (int i = 0; i < NUM_M; i++) begin
            req_pad[i] = req[i];
            we_arr[i]  = bus.m_we[i];
            adr_arr[i] = bus.m_adr[i*ADDR_W +: ADDR_W];
            sel_arr[i] = bus.m_sel[i*SEL_W +: SEL_W];
            dat_arr[i] = bus.m_dat_w[i*DATA_W +: DATA_W];
        end
    end

    assign granted     = (state == GRANT);
    assign gnt_req     = req_pad[gnt_idx];
    assign busy        = granted;
    assign bus.s_cyc   = granted;
    assign bus.s_stb   = granted;
    assign bus.s_we    = granted & we_arr[gnt_idx];
    assign bus.s_adr   = granted ? adr_arr[gnt_idx] : '0;
    assign bus.s_sel   = granted ? sel_arr[gnt_idx] : '0;
    assign bus.s_dat_w = granted ? dat_arr[gnt_idx] : '0;
    assign bus.m_dat_r = bus.s_dat_r;

    always_comb begin
        bus.m_ack = '0;
        bus.m_rty = '0;
        for (int i = 0; i < NUM_M; i++) begin
            bus.m_ack[i] = granted && (gnt_idx == 3'(i)) && bus.s_ack;
            bus.m_rty[i] = granted && (gnt_idx == 3'(i)) && bus.s_rty;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            gnt_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    // Ack wins over a simultaneous request drop; retry and abort leave counters and rr_ptr alone.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            gnt_idx <= 3'd0;
            rr_ptr  <= 3'd0;
            for (int i = 0; i < NUM_M; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_idx <= win;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (bus.s_ack) begin
                        state  <= IDLE;
                        rr_ptr <= (gnt_idx == LAST_IDX) ? 3'd0 : gnt_idx + 3'd1;
                        for (int i = 0; i < NUM_M; i++) begin
                            if ((gnt_idx == 3'(i)) && (cnt[i] != '1)) begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                    end else if (bus.s_rty || !gnt_req) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed self-checking bench for wb_arbiter_n with four masters and 4-bit grant counters.
module tb_wb_arbiter_n;
    localparam int NUM_M  = 4;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 4;

    logic                   CLK     = 1'b0;
    logic                   RST_N   = 1'b0;
    logic                   mode_rr = 1'b0;
    logic [NUM_M*CNT_W-1:0] gnt_cnt;
    logic                   busy;
    int                     n_chk   = 0;
    int                     n_pass  = 0;

    wb_arbiter_n_if #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    wb_arbiter_n #(
        .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .mode_rr (mode_rr),
        .bus     (bus),
        .gnt_cnt (gnt_cnt),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v);
        bus.m_cyc[i] = v;
        bus.m_stb[i] = v;
    endtask

    task automatic init_bus();
        bus.m_cyc   = '0;
        bus.m_stb   = '0;
        bus.m_we    = 4'b1010;
        bus.s_ack   = 1'b0;
        bus.s_rty   = 1'b0;
        bus.s_dat_r = '0;
        for (int i = 0; i < NUM_M; i++) begin
            bus.m_adr[i*ADDR_W +: ADDR_W]   = 12'h100 + 12'(i);
            bus.m_sel[i*SEL_W +: SEL_W]     = 4'(1 << i);
            bus.m_dat_w[i*DATA_W +: DATA_W] = 32'hD000_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        bus.m_cyc = '0;
        bus.m_stb = '0;
        bus.s_ack = 1'b0;
        bus.s_rty = 1'b0;
        RST_N     = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        init_bus();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        set_req(2, 1'b1);
        tick();
        n_chk++; if (bus.s_stb !== 1'b1) $display("FAIL reset_pre_grant s_stb got=%b exp=1", bus.s_stb); else n_pass++;
        n_chk++; if (bus.s_adr !== 12'h102) $display("FAIL reset_pre_grant s_adr got=%h exp=102", bus.s_adr); else n_pass++;
        bus.s_ack = 1'b1;
        RST_N     = 1'b0;
        tick();
        n_chk++; if (bus.s_stb !== 1'b0) $display("FAIL reset_s_stb got=%b exp=0", bus.s_stb); else n_pass++;
        n_chk++; if (bus.m_ack !== 4'b0000) $display("FAIL reset_m_ack got=%b exp=0000", bus.m_ack); else n_pass++;
        n_chk++; if (gnt_cnt !== 16'h0000) $display("FAIL reset_gnt_cnt got=%h exp=0000", gnt_cnt); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (bus.s_cyc !== 1'b0) $display("FAIL reset_s_cyc got=%b exp=0", bus.s_cyc); else n_pass++;
        RST_N     = 1'b1;
        bus.s_ack = 1'b0;
        set_req(2, 1'b0);
        bus.s_dat_r = 32'hA5A5_5A5A;
        #1;
        n_chk++; if (bus.m_dat_r !== 32'hA5A5_5A5A) $display("FAIL reset_m_dat_r got=%h exp=a5a55a5a", bus.m_dat_r); else n_pass++;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_fixed();
        mode_rr = 1'b0;
        set_req(1, 1'b1);
        set_req(3, 1'b1);
        tick();
        n_chk++; if (bus.s_adr !== 12'h101) $display("FAIL fixed_first s_adr got=%h exp=101", bus.s_adr); else n_pass++;
        n_chk++; if (bus.s_we !== 1'b1) $display("FAIL fixed_first s_we got=%b exp=1", bus.s_we); else n_pass++;
        n_chk++; if (bus.s_sel !== 4'h2) $display("FAIL fixed_first s_sel got=%h exp=2", bus.s_sel); else n_pass++;
        n_chk++; if (bus.s_dat_w !== 32'hD000_0001) $display("FAIL fixed_first s_dat_w got=%h exp=d0000001", bus.s_dat_w); else n_pass++;
        tick();
        tick();
        n_chk++; if (bus.m_ack !== 4'b0000) $display("FAIL fixed_wait m_ack got=%b exp=0000", bus.m_ack); else n_pass++;
        bus.s_ack   = 1'b1;
        bus.s_dat_r = 32'h1234_5678;
        #1;
        n_chk++; if (bus.m_ack !== 4'b0010) $display("FAIL fixed_ack1 m_ack got=%b exp=0010", bus.m_ack); else n_pass++;
        n_chk++; if (bus.m_dat_r !== 32'h1234_5678) $display("FAIL fixed_ack1 m_dat_r got=%h exp=12345678", bus.m_dat_r); else n_pass++;
        tick();
        bus.s_ack = 1'b0;
        set_req(1, 1'b0);
        #1;
        n_chk++; if (bus.s_stb !== 1'b0) $display("FAIL fixed_gap s_stb got=%b exp=0", bus.s_stb); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL fixed_gap busy got=%b exp=0", busy); else n_pass++;
        tick();
        n_chk++; if (bus.s_stb !== 1'b1) $display("FAIL fixed_second s_stb got=%b exp=1", bus.s_stb); else n_pass++;
        n_chk++; if (bus.s_adr !== 12'h103) $display("FAIL fixed_second s_adr got=%h exp=103", bus.s_adr); else n_pass++;
        bus.s_ack = 1'b1;
        #1;
        n_chk++; if (bus.m_ack !== 4'b1000) $display("FAIL fixed_ack3 m_ack got=%b exp=1000", bus.m_ack); else n_pass++;
        tick();
        bus.s_ack = 1'b0;
        set_req(3, 1'b0);
        n_chk++; if (gnt_cnt !== 16'h1010) $display("FAIL fixed_gnt_cnt got=%h exp=1010", gnt_cnt); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        mode_rr = 1'b1;
        for (int i = 0; i < NUM_M; i++) set_req(i, 1'b1);
        for (int g = 0; g < 5; g++) begin
            tick();
            n_chk++; if (bus.s_adr !== 12'h100 + 12'(exp_order[g]))
                $display("FAIL rr_order[%0d] s_adr got=%h exp=%h", g, bus.s_adr, 12'h100 + 12'(exp_order[g]));
            else n_pass++;
            bus.s_ack = 1'b1;
            #1;
            n_chk++; if (bus.m_ack !== 4'(1 << exp_order[g]))
                $display("FAIL rr_ack[%0d] m_ack got=%b exp=%b", g, bus.m_ack, 4'(1 << exp_order[g]));
            else n_pass++;
            tick();
            bus.s_ack = 1'b0;
            #1;
            n_chk++; if (busy !== 1'b0) $display("FAIL rr_gap[%0d] busy got=%b exp=0", g, busy); else n_pass++;
        end
        for (int i = 0; i < NUM_M; i++) set_req(i, 1'b0);
        n_chk++; if (gnt_cnt !== 16'h1112) $display("FAIL rr_gnt_cnt got=%h exp=1112", gnt_cnt); else n_pass++;
    endtask

    task automatic test_retry();
        do_reset();
        mode_rr = 1'b1;
        set_req(1, 1'b1);
        tick();
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        set_req(1, 1'b0);
        set_req(2, 1'b1);
        set_req(3, 1'b1);
        tick();
        n_chk++; if (bus.s_adr !== 12'h102) $display("FAIL retry_grant s_adr got=%h exp=102", bus.s_adr); else n_pass++;
        bus.s_rty = 1'b1;
        #1;
        n_chk++; if (bus.m_rty !== 4'b0100) $display("FAIL retry_m_rty got=%b exp=0100", bus.m_rty); else n_pass++;
        n_chk++; if (bus.m_ack !== 4'b0000) $display("FAIL retry_m_ack got=%b exp=0000", bus.m_ack); else n_pass++;
        tick();
        bus.s_rty = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL retry_idle busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (gnt_cnt !== 16'h0010) $display("FAIL retry_gnt_cnt got=%h exp=0010", gnt_cnt); else n_pass++;
        tick();
        n_chk++; if (bus.s_adr !== 12'h102) $display("FAIL retry_regrant s_adr got=%h exp=102", bus.s_adr); else n_pass++;
        bus.s_ack = 1'b1;
        #1;
        n_chk++; if (bus.m_ack !== 4'b0100) $display("FAIL retry_ack m_ack got=%b exp=0100", bus.m_ack); else n_pass++;
        tick();
        bus.s_ack = 1'b0;
        set_req(2, 1'b0);
        tick();
        n_chk++; if (bus.s_adr !== 12'h103) $display("FAIL retry_next s_adr got=%h exp=103", bus.s_adr); else n_pass++;
        bus.s_ack = 1'b1;
        tick();
        bus.s_ack = 1'b0;
        set_req(3, 1'b0);
        n_chk++; if (gnt_cnt !== 16'h1110) $display("FAIL retry_final_cnt got=%h exp=1110", gnt_cnt); else n_pass++;
    endtask

    task automatic test_abort();
        do_reset();
        mode_rr = 1'b0;
        set_req(0, 1'b1);
        set_req(1, 1'b1);
        tick();
        n_chk++; if (bus.s_adr !== 12'h100) $display("FAIL abort_grant s_adr got=%h exp=100", bus.s_adr); else n_pass++;
        bus.m_stb[0] = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL abort_idle busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (bus.m_ack !== 4'b0000) $display("FAIL abort_m_ack got=%b exp=0000", bus.m_ack); else n_pass++;
        n_chk++; if (gnt_cnt !== 16'h0000) $display("FAIL abort_gnt_cnt got=%h exp=0000", gnt_cnt); else n_pass++;
        tick();
        n_chk++; if (bus.s_adr !== 12'h101) $display("FAIL abort_pending s_adr got=%h exp=101", bus.s_adr); else n_pass++;
        bus.s_ack = 1'b1;
        #1;
        n_chk++; if (bus.m_ack !== 4'b0010) $display("FAIL abort_ack1 m_ack got=%b exp=0010", bus.m_ack); else n_pass++;
        tick();
        bus.s_ack = 1'b0;
        set_req(0, 1'b0);
        set_req(1, 1'b0);
        n_chk++; if (gnt_cnt !== 16'h0010) $display("FAIL abort_final_cnt got=%h exp=0010", gnt_cnt); else n_pass++;
    endtask

    task automatic test_ack_with_drop();
        do_reset();
        mode_rr = 1'b0;
        set_req(0, 1'b1);
        tick();
        bus.s_ack = 1'b1;
        set_req(0, 1'b0);
        #1;
        n_chk++; if (bus.m_ack !== 4'b0001) $display("FAIL ackdrop_m_ack got=%b exp=0001", bus.m_ack); else n_pass++;
        tick();
        bus.s_ack = 1'b0;
        n_chk++; if (gnt_cnt !== 16'h0001) $display("FAIL ackdrop_gnt_cnt got=%h exp=0001", gnt_cnt); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL ackdrop_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        mode_rr = 1'b0;
        set_req(0, 1'b1);
        for (int n = 1; n <= 17; n++) begin
            tick();
            bus.s_ack = 1'b1;
            tick();
            bus.s_ack = 1'b0;
            if (n == 15) begin
                n_chk++; if (gnt_cnt[3:0] !== 4'd15) $display("FAIL sat_at15 gnt_cnt0 got=%0d exp=15", gnt_cnt[3:0]); else n_pass++;
            end
        end
        set_req(0, 1'b0);
        n_chk++; if (gnt_cnt !== 16'h000F) $display("FAIL sat_final gnt_cnt got=%h exp=000f", gnt_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_retry();
        test_abort();
        test_ack_with_drop();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
